jt12_i2s_tx: RTL and testbench
==============================

JT12_I2S_TX -- requirements
Module: jt12_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 4: clk cycles per bclk half-period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all flops on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port left  input  14  signed left sample, from the channel accumulator output.
REQ-005 SHALL have port right  input  14  signed right sample.
REQ-006 SHALL have port sample  input  1  one-cycle strobe, left/right valid this cycle.
REQ-007 SHALL have port clr_flags  input  1  synchronous clear of sticky flags.
REQ-008 SHALL have port bclk  output  1  I2S bit clock.
REQ-009 SHALL have port lrclk  output  1  I2S word select; 0 = left.
REQ-010 SHALL have port sdata  output  1  I2S serial data, MSB first.
REQ-011 SHALL have port overrun  output  1  sticky: a held sample was overwritten before transmission.
REQ-012 SHALL have port underrun  output  1  sticky: frame started with no new sample.

Function
REQ-013 SHALL hold one stereo pair in a holding register with valid bit hv; sample sets hv and captures left/right.
REQ-014 SHALL set overrun when sample arrives with hv=1 and no frame load in the same cycle; the new sample overwrites the old one.
REQ-015 SHALL form each transmitted word as {sample[13:0], 2'b00}, 16 bits, two's complement.
REQ-016 SHALL implement states IDLE and RUN; IDLE holds bclk=0, lrclk=0, sdata=0, and the divider is stopped.
REQ-017 SHALL leave IDLE for RUN on the cycle after the first sample; on entry it performs a frame load with div_cnt=0, bclk=0, slot=0.
REQ-018 SHALL toggle bclk when div_cnt reaches BCLK_DIV-1, then reset div_cnt to 0; bclk period = 2*BCLK_DIV clk cycles.
REQ-019 SHALL advance slot 0..31 (wrapping 31->0) and update sdata/lrclk only on bclk falling toggles; sdata is stable across each rising edge.
REQ-020 SHALL drive left bits 15..0 in slots 0..15 and right bits 15..0 in slots 16..31.
REQ-021 SHALL drive lrclk=1 in slots 15..30 and lrclk=0 in slots 31 and 0..14, i.e. one slot ahead of the data (standard I2S).
REQ-022 SHALL perform a frame load on the falling toggle entering slot 0: the shift register takes the holding register and hv clears.
REQ-023 SHALL, at a frame load with hv=0, retransmit the previous pair and set underrun.
REQ-024 SHALL, when sample and frame load coincide, transmit the old holding pair, store the new pair with hv=1, and not set overrun.
REQ-025 SHALL clear overrun/underrun on clr_flags; a set event in the same cycle wins over the clear.
REQ-026 SHALL stay in RUN until reset; sample cadence and bclk are asynchronous to each other, with no other ordering assumed.

Reset
REQ-027 SHALL, while rst=0, force IDLE, bclk=0, lrclk=0, sdata=0, overrun=0, underrun=0, hv=0, slot=0, div_cnt=0, and shift/holding registers=0, immediately and regardless of clk.
REQ-028 SHALL resume in IDLE after reset release mid-frame; no partial frame completes.

Structure
REQ-029 SHALL take constants I2S_SLOTS=32 and I2S_WORD=16 and the state enum {IDLE, RUN} from shared package jt12_pkg.
REQ-030 SHALL instantiate a single sub-module jt12_i2s_div, a divider producing one-cycle rise/fall enables and the bclk level; the holding register, shifter and FSM stay in jt12_i2s_tx.

Verification
REQ-031 SHALL test: BCLK_DIV=2, sample with left=14'h1FFF, right=14'h2000 -> first frame slots 0..15 = 16'h7FFC, slots 16..31 = 16'h8000; bclk period 4 clk.
REQ-032 SHALL test: no further sample after the first -> the second frame repeats the same words and underrun=1 at the slot-0 load; clr_flags -> underrun=0.
REQ-033 SHALL test: two samples (0x0001/0x0002, then 0x0003/0x0004) within one frame -> the next frame sends 16'h000C/16'h0010 and overrun=1.
REQ-034 SHALL test: sample on the exact frame-load cycle -> the old pair is transmitted, the new pair goes out next frame, overrun stays 0.
REQ-035 SHALL test: rst asserted at slot 20 -> all outputs 0 within the same cycle; after release the bench stays in IDLE until the next sample.
REQ-036 SHALL test: lrclk check over 3 frames -> each lrclk edge occurs exactly one bclk before the MSB of its channel; BCLK_DIV=1 gives a 2-clk bclk period.

Source files
------------

// File: rtl/jt12_pkg.sv
// Shared constants, state type and word helpers for the I2S transmitter.
// Word layout is the 14-bit accumulator sample left-justified in 16 bits.
package jt12_pkg;

    localparam int I2S_SLOTS = 32;
    localparam int I2S_WORD  = 16;
    localparam int SMP_W     = 14;

    typedef enum logic {
        IDLE,
        RUN
    } i2s_state_e;

    function automatic logic [I2S_WORD-1:0] i2s_word(
        input logic [SMP_W-1:0] s
    );
        return {s, 2'b00};
    endfunction

    // lrclk leads the data by one slot
    function automatic logic lr_of_slot(input logic [4:0] slot);
        return (slot >= 5'd15) && (slot <= 5'd30);
    endfunction

endpackage

// File: rtl/jt12_i2s_div.sv
// Bit-clock divider: bclk level plus one-cycle rise/fall enables.
// Held at zero (count and level) whenever en is low.
module jt12_i2s_div #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bclk,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt_q, cnt_d;
    logic       bclk_q, bclk_d;
    logic       tick;

    assign tick = en && (cnt_q == 8'(BCLK_DIV - 1));
    assign rise = tick && !bclk_q;
    assign fall = tick && bclk_q;
    assign bclk = bclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (!en) begin
            cnt_d  = 8'd0;
            bclk_d = 1'b0;
        end else if (tick) begin
            cnt_d  = 8'd0;
            bclk_d = !bclk_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 8'd0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

endmodule

// File: rtl/jt12_i2s_tx.sv
// I2S transmitter for the stereo accumulator output: one-pair holding
// register, 32-slot shifter and sticky overrun/underrun flags.
module jt12_i2s_tx
    import jt12_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [13:0]  left,
    input  logic [13:0]  right,
    input  logic         sample,
    input  logic         clr_flags,
    output logic         bclk,
    output logic         lrclk,
    output logic         sdata,
    output logic         overrun,
    output logic         underrun
);

    i2s_state_e  state_q, state_d;
    logic [13:0] hl_q, hl_d;
    logic [13:0] hr_q, hr_d;
    logic        hv_q, hv_d;
    logic [31:0] shift_q, shift_d;
    logic [4:0]  slot_q, slot_d;
    logic        lrclk_q, lrclk_d;
    logic        ovr_q, ovr_d;
    logic        unr_q, unr_d;

    logic        run;
    logic        bclk_fall;
    logic        unused_rise;
    logic        load;
    logic        ovr_set;
    logic        unr_set;

    assign run = (state_q == RUN);

    jt12_i2s_div #(
        .BCLK_DIV (BCLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .bclk (bclk),
        .rise (unused_rise),
        .fall (bclk_fall)
    );

    always_comb begin
        state_d = state_q;
        hl_d    = hl_q;
        hr_d    = hr_q;
        hv_d    = hv_q;
        shift_d = shift_q;
        slot_d  = slot_q;
        lrclk_d = lrclk_q;
        load    = 1'b0;
        ovr_set = 1'b0;
        unr_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hv_q) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bclk_fall) begin
                    if (slot_q == 5'(I2S_SLOTS - 1)) begin
                        load = 1'b1;
                    end else begin
                        slot_d  = slot_q + 5'd1;
                        shift_d = {shift_q[30:0], 1'b0};
                        lrclk_d = lr_of_slot(slot_q + 5'd1);
                    end
                end
            end
        endcase

        // An empty holding register replays the last pair
        if (load) begin
            slot_d  = 5'd0;
            shift_d = {i2s_word(hl_q), i2s_word(hr_q)};
            lrclk_d = 1'b0;
            hv_d    = 1'b0;
            unr_set = !hv_q;
        end

        if (sample) begin
            ovr_set = hv_q && !load;
            hl_d    = left;
            hr_d    = right;
            hv_d    = 1'b1;
        end

        ovr_d = ovr_set ? 1'b1 : (clr_flags ? 1'b0 : ovr_q);
        unr_d = unr_set ? 1'b1 : (clr_flags ? 1'b0 : unr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hl_q    <= '0;
            hr_q    <= '0;
            hv_q    <= 1'b0;
            shift_q <= '0;
            slot_q  <= '0;
            lrclk_q <= 1'b0;
            ovr_q   <= 1'b0;
            unr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hl_q    <= hl_d;
            hr_q    <= hr_d;
            hv_q    <= hv_d;
            shift_q <= shift_d;
            slot_q  <= slot_d;
            lrclk_q <= lrclk_d;
            ovr_q   <= ovr_d;
            unr_q   <= unr_d;
        end
    end

    assign sdata    = shift_q[31];
    assign lrclk    = lrclk_q;
    assign overrun  = ovr_q;
    assign underrun = unr_q;

endmodule

// File: tb/tb_jt12_i2s_tx.sv
// Bench for jt12_i2s_tx: expected frames queued by stimulus, checked by a
// bclk-driven monitor; flags and reset behaviour checked at exact cycles.
module tb_jt12_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] left = '0;
    logic [13:0] right = '0;
    logic        sample = 1'b0;
    logic        sample1 = 1'b0;
    logic        clr_flags = 1'b0;

    logic bclk, lrclk, sdata, overrun, underrun;
    logic bclk1, lrclk1, sdata1, overrun1, underrun1;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jt12_i2s_tx #(.BCLK_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .left      (left),
        .right     (right),
        .sample    (sample),
        .clr_flags (clr_flags),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .overrun   (overrun),
        .underrun  (underrun)
    );

    jt12_i2s_tx #(.BCLK_DIV(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .left      (left),
        .right     (right),
        .sample    (sample1),
        .clr_flags (clr_flags),
        .bclk      (bclk1),
        .lrclk     (lrclk1),
        .sdata     (sdata1),
        .overrun   (overrun1),
        .underrun  (underrun1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic lr_exp(input int s);
        return (s >= 15) && (s <= 30);
    endfunction

    // Monitor: one bit per bclk rise, one frame compared per slot 31
    logic        m_prev = 1'b0;
    int          m_slot = 0;
    int          m_pc = 0;
    int          m_per = 0;
    logic [31:0] m_word = '0;
    logic        m_lrbad = 1'b0;
    logic        m_perbad = 1'b0;

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_prev   = 1'b0;
                m_slot   = 0;
                m_pc     = 0;
                m_word   = '0;
                m_lrbad  = 1'b0;
                m_perbad = 1'b0;
            end else begin
                m_pc++;
                if (bclk && !m_prev) begin
                    m_per = m_pc;
                    m_pc  = 0;
                    if (m_slot != 0 && m_per != 4) m_perbad = 1'b1;
                    if (lrclk !== lr_exp(m_slot)) m_lrbad = 1'b1;
                    m_word = {m_word[30:0], sdata};
                    if (m_slot == 31) begin
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            chk("frame_data", m_word, e);
                            chk("lrclk_align", 32'(m_lrbad), 32'd0);
                            chk("bclk_period", 32'(m_perbad), 32'd0);
                        end
                        m_lrbad  = 1'b0;
                        m_perbad = 1'b0;
                    end
                    m_slot = (m_slot + 1) % 32;
                end
                m_prev = bclk;
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic sample_at(input int p, input logic [13:0] l,
                             input logic [13:0] r);
        wait_cyc(p - 1);
        left   = l;
        right  = r;
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
    endtask

    task automatic clr_at(input int p);
        wait_cyc(p - 1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        sample    = 1'b0;
        sample1   = 1'b0;
        clr_flags = 1'b0;
        repeat (3) @(negedge clk);
        q.delete();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input int lim);
        int k = 0;
        while (q.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int hi;
        logic p1;
        int nr, pc;
        logic [31:0] w;
        logic lrbad, perbad;

        // reset state, then idle with no sample
        repeat (2) @(negedge clk);
        chk("reset_outs", {27'd0, bclk, lrclk, sdata, overrun, underrun}, 0);
        rst = 1'b1;
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (bclk || lrclk || sdata) hi++;
        end
        chk("idle_quiet", 32'(hi), 32'd0);

        // first frame, then underrun replay, clear, set-beats-clear
        sample_at(cyc + 2, 14'h1FFF, 14'h2000);
        e = cyc + 1;
        repeat (3) q.push_back({16'h7FFC, 16'h8000});
        wait_cyc(e + 127);
        chk("unr_before_load", 32'(underrun), 32'd0);
        wait_cyc(e + 128);
        chk("unr_at_load", 32'(underrun), 32'd1);
        chk("ovr_t1", 32'(overrun), 32'd0);
        clr_at(e + 140);
        chk("unr_cleared", 32'(underrun), 32'd0);
        clr_at(e + 256);
        chk("unr_set_wins", 32'(underrun), 32'd1);
        drain(600);

        // overrun and sample coinciding with a frame load
        do_reset();
        sample_at(cyc + 2, 14'h0100, 14'h0200);
        e = cyc + 1;
        q.push_back({16'h0400, 16'h0800});
        sample_at(e + 20, 14'h0001, 14'h0002);
        chk("ovr_first", 32'(overrun), 32'd0);
        sample_at(e + 40, 14'h0003, 14'h0004);
        chk("ovr_second", 32'(overrun), 32'd1);
        q.push_back({16'h000C, 16'h0010});
        wait_cyc(e + 128);
        chk("unr_f2", 32'(underrun), 32'd0);
        clr_at(e + 140);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        sample_at(e + 160, 14'h0005, 14'h0006);
        q.push_back({16'h0014, 16'h0018});
        sample_at(e + 256, 14'h0007, 14'h0008);
        q.push_back({16'h001C, 16'h0020});
        chk("coincide_flags", {30'd0, overrun, underrun}, 32'd0);
        wait_cyc(e + 384);
        chk("unr_f4", 32'(underrun), 32'd0);
        drain(700);

        // asynchronous reset at slot 20, then resume from IDLE
        do_reset();
        sample_at(cyc + 2, 14'h0123, 14'h0200);
        e = cyc + 1;
        wait_cyc(e + 82);
        chk("pre_reset", {29'd0, bclk, lrclk, sdata}, 32'd7);
        #1 rst = 1'b0;
        #1 chk("async_reset",
               {27'd0, bclk, lrclk, sdata, overrun, underrun}, 32'd0);
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (bclk || lrclk || sdata) hi++;
        end
        chk("idle_after_reset", 32'(hi), 32'd0);
        sample_at(cyc + 2, 14'h1234, 14'h0567);
        q.push_back({16'h48D0, 16'h159C});
        drain(300);

        // BCLK_DIV=1 instance: 2-clk bclk period and frame content
        do_reset();
        wait_cyc(cyc + 1);
        left    = 14'h0AAA;
        right   = 14'h1555;
        sample1 = 1'b1;
        @(negedge clk);
        sample1 = 1'b0;
        p1 = 1'b0;
        nr = 0;
        pc = 0;
        w = '0;
        lrbad = 1'b0;
        perbad = 1'b0;
        for (int i = 0; i < 200 && nr < 32; i++) begin
            @(negedge clk);
            pc++;
            if (bclk1 && !p1) begin
                if (nr > 0 && pc != 2) perbad = 1'b1;
                pc = 0;
                if (lrclk1 !== lr_exp(nr)) lrbad = 1'b1;
                w = {w[30:0], sdata1};
                nr++;
            end
            p1 = bclk1;
        end
        chk("div1_rises", 32'(nr), 32'd32);
        chk("div1_word", w, {16'h2AA8, 16'h5554});
        chk("div1_period", 32'(perbad), 32'd0);
        chk("div1_lrclk", 32'(lrbad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
